bram_host_port_driver: RTL and testbench
========================================

# bram_host_port_driver

Sequencer that owns the byte-wide host port of the local-memory `bram`. In LOAD mode it accepts a valid/ready byte stream from the host and writes one full line, byte k at offset 8k+7, using `host_input`, `offset` and `line_read_from_host`. In DUMP mode it walks the same offsets, reads `bram_to_host` and streams the line back to the host over valid/ready. It sits between the host interface and `bram`, and is the counterpart of the bram's host-side write and read port.

## Interface
- `num_bits`, 512, line width in bits; must be a multiple of 8; N = num_bits/8 bytes per line
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset
- `load_start`  in  1  in IDLE, begin a LOAD of N bytes
- `dump_start`  in  1  in IDLE, begin a DUMP of N bytes
- `host_in_data`  in  8  byte from host (LOAD)
- `host_in_valid`  in  1  host_in_data valid
- `host_in_ready`  out  1  driver accepts byte this cycle
- `host_out_data`  out  8  byte to host (DUMP)
- `host_out_valid`  out  1  host_out_data valid
- `host_out_ready`  in  1  host accepts byte this cycle
- `host_input`  out  8  to bram, write byte
- `offset`  out  $clog2(num_bits)  to bram, top-bit index of the addressed byte (8k+7)
- `line_read_from_host`  out  1  to bram, write strobe (one byte per asserted cycle)
- `bram_to_host`  in  8  from bram, combinational read of the byte at `offset`
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at the end of LOAD or DUMP

## Operation
- States: IDLE, LOAD, DUMP, DRAIN, DONE. Byte index `idx` has width $clog2(N)+1.
- IDLE:
  - `load_start` goes to LOAD with idx=0.
  - Else `dump_start` goes to DUMP with idx=0 and `offset`=7.
  - Both high at once: LOAD wins.
  - Starts are ignored in every other state.
- LOAD:
  - `host_in_ready`=1 while idx<N.
  - On an accept (valid&ready), register `host_input`=host_in_data, `offset`=8·idx+7 and `line_read_from_host`=1 for exactly the next cycle, then idx++.
  - Cycles without an accept drive `line_read_from_host`=0 next cycle.
  - The accept with idx=N-1 goes to DONE. `host_in_ready` is 0 from that edge on.
  - The final write strobe is therefore asserted during the DONE cycle.
- DUMP:
  - `offset`=8·idx+7 is registered.
  - When the output slot is free (!host_out_valid or host_out_ready), capture `host_out_data`←`bram_to_host`, set `host_out_valid`=1, idx++ and update `offset`.
  - After the capture of byte N-1, go to DRAIN.
  - `line_read_from_host` stays 0 throughout DUMP.
- DRAIN: hold `host_out_valid`/`host_out_data` until `host_out_ready`, then clear valid and go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Stalls:
  - The output slot holds data stable while valid && !ready.
  - Bytes are never dropped or duplicated.
- Reset, asynchronous and active-low, returns to IDLE from any state, including mid-LOAD or mid-DUMP. No further writes are issued. The partial line in bram is left as is.
- Reset values of all outputs: `host_in_ready`=0, `host_out_valid`=0, `host_out_data`=0, `host_input`=0, `offset`=0, `line_read_from_host`=0, `busy`=0, `done`=0.

## Timing
- LOAD:
  - `load_start` at edge E moves to LOAD after E.
  - `host_in_ready`=1 in the cycle after E.
  - Each write strobe follows its accept by 1 cycle.
  - With continuous valid: N writes on N consecutive cycles, with `done` together with the last strobe.
- DUMP:
  - `dump_start` at edge E moves to DUMP after E, with `offset`=7 in the cycle after E.
  - First `host_out_valid` appears 2 cycles after E.
  - With `host_out_ready` held at 1: one byte per cycle, N bytes back-to-back.
  - `done` follows 1 cycle after the last handshake.
- `busy` rises the cycle after a start and falls after the DONE cycle.

## Test plan
- Reset, then LOAD with bytes 0x01..0x40 (num_bits=512), valid held high.
  - Expect 64 consecutive strobes with offsets 7,15,…,511 and data 0x01..0x40.
  - Expect `done` with the last strobe.
  - The bram `chunk_out` then equals the packed bytes.
- LOAD with host_in_valid toggling 1,0,0,1…
  - Expect strobes only on the cycle after each accept.
  - Expect no strobe on gap cycles, the same final line contents, and exactly 64 writes.
- DUMP after the first scenario with host_out_ready=1.
  - Expect the 64 output bytes 0x01..0x40 in order, one per cycle, first valid 2 cycles after start.
- DUMP with host_out_ready low for 3 cycles at bytes 5 and 63.
  - Expect data held stable while stalled.
  - Expect the sequence intact and `done` only after the last handshake.
- `load_start` and `dump_start` high in the same cycle.
  - Expect LOAD.
  - `dump_start` pulses during the LOAD are ignored, and `busy` stays 1.
- Drop `rst` low after 20 accepted bytes.
  - Expect all outputs at their reset values immediately and no further strobes.
  - A fresh LOAD afterwards restarts at offset 7.

Source files
------------

// File: rtl/bram_host_port_driver.sv
// Host-side sequencer for the local bram: streams one line in from the host (LOAD)
// or back out to the host (DUMP), one byte per handshake.
module bram_host_port_driver #(
   parameter int NUM_BITS = 512,
   localparam int OFFW = $clog2(NUM_BITS)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            load_start_i,
   input  logic            dump_start_i,
   input  logic [7:0]      host_in_data_i,
   input  logic            host_in_valid_i,
   output logic            host_in_ready_o,
   output logic [7:0]      host_out_data_o,
   output logic            host_out_valid_o,
   input  logic            host_out_ready_i,
   output logic [7:0]      host_input_o,
   output logic [OFFW-1:0] offset_o,
   output logic            line_read_from_host_o,
   input  logic [7:0]      bram_to_host_i,
   output logic            busy_o,
   output logic            done_o
);

   // state  | meaning
   // IDLE   | waiting for load_start / dump_start (load wins)
   // LOAD   | accepting host bytes, one registered bram write per accept
   // DUMP   | reading bram at offset, refilling the output slot when free
   // DRAIN  | last byte captured, waiting for the host to take it
   // DONE   | one-cycle done pulse (final LOAD strobe lands here)

   localparam int N = NUM_BITS / 8;
   localparam int IDXW = $clog2(N) + 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
   localparam logic [IDXW-1:0] N_IDX    = IDXW'(N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DUMP,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      odata_q, odata_d;
   logic [OFFW-1:0] offset_q, offset_d;
   logic            wr_q, wr_d;
   logic            ovalid_q, ovalid_d;
   logic            accept;
   logic            slot_free;

   // Offset of a byte is its top bit index, 8*idx+7.
   function automatic logic [OFFW-1:0] top_bit(input logic [IDXW-1:0] idx);
      return {idx[IDXW-2:0], 3'b111};
   endfunction

   assign host_in_ready_o = (state_q == S_LOAD) && (idx_q < N_IDX);
   assign accept          = host_in_valid_i && host_in_ready_o;
   assign slot_free       = !ovalid_q || host_out_ready_i;

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      odata_d  = odata_q;
      offset_d = offset_q;
      wr_d     = 1'b0;
      ovalid_d = ovalid_q;
      unique case (state_q)
         S_IDLE: begin
            if (load_start_i) begin
               state_d = S_LOAD;
               idx_d   = '0;
            end else if (dump_start_i) begin
               state_d  = S_DUMP;
               idx_d    = '0;
               offset_d = top_bit('0);
            end
         end
         S_LOAD: begin
            if (accept) begin
               wr_d     = 1'b1;
               wdata_d  = host_in_data_i;
               offset_d = top_bit(idx_q);
               idx_d    = idx_q + IDXW'(1);
               if (idx_q == LAST_IDX) state_d = S_DONE;
            end
         end
         S_DUMP: begin
            if (slot_free) begin
               odata_d  = bram_to_host_i;
               ovalid_d = 1'b1;
               idx_d    = idx_q + IDXW'(1);
               offset_d = top_bit(idx_q + IDXW'(1));
               if (idx_q == LAST_IDX) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (host_out_ready_i) begin
               ovalid_d = 1'b0;
               state_d  = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         wdata_q  <= '0;
         odata_q  <= '0;
         offset_q <= '0;
         wr_q     <= 1'b0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         odata_q  <= odata_d;
         offset_q <= offset_d;
         wr_q     <= wr_d;
         ovalid_q <= ovalid_d;
      end
   end

   assign host_out_data_o       = odata_q;
   assign host_out_valid_o      = ovalid_q;
   assign host_input_o          = wdata_q;
   assign offset_o              = offset_q;
   assign line_read_from_host_o = wr_q;
   assign busy_o                = (state_q != S_IDLE);
   assign done_o                = (state_q == S_DONE);

endmodule

// File: tb/tb_bram_host_port_driver.sv
// Randomized self-checking bench for bram_host_port_driver with a behavioural bram
// and a byte-sequence reference model.
module tb_bram_host_port_driver;

   localparam int NB = 512;
   localparam int N  = NB / 8;
   localparam int OW = $clog2(NB);

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          load_start_i, dump_start_i;
   logic [7:0]    host_in_data_i;
   logic          host_in_valid_i;
   logic          host_in_ready_o;
   logic [7:0]    host_out_data_o;
   logic          host_out_valid_o;
   logic          host_out_ready_i;
   logic [7:0]    host_input_o;
   logic [OW-1:0] offset_o;
   logic          line_read_from_host_o;
   logic [7:0]    bram_to_host_i;
   logic          busy_o, done_o;

   int nchk = 0;
   int nerr = 0;

   logic [7:0]    ld_data [N];
   logic [NB-1:0] mem = '0;

   bram_host_port_driver #(.NUM_BITS(NB)) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .load_start_i          (load_start_i),
      .dump_start_i          (dump_start_i),
      .host_in_data_i        (host_in_data_i),
      .host_in_valid_i       (host_in_valid_i),
      .host_in_ready_o       (host_in_ready_o),
      .host_out_data_o       (host_out_data_o),
      .host_out_valid_o      (host_out_valid_o),
      .host_out_ready_i      (host_out_ready_i),
      .host_input_o          (host_input_o),
      .offset_o              (offset_o),
      .line_read_from_host_o (line_read_from_host_o),
      .bram_to_host_i        (bram_to_host_i),
      .busy_o                (busy_o),
      .done_o                (done_o)
   );

   always #5 clk_i = ~clk_i;

   // behavioural bram: byte write at top-bit offset, combinational read
   always @(posedge clk_i) if (line_read_from_host_o) mem[offset_o -: 8] <= host_input_o;
   assign bram_to_host_i = mem[offset_o -: 8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      if (obs !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rdy",   32'(host_in_ready_o), 0);
      chk("rst_ovld",  32'(host_out_valid_o), 0);
      chk("rst_odat",  32'(host_out_data_o), 0);
      chk("rst_wdat",  32'(host_input_o), 0);
      chk("rst_off",   32'(offset_o), 0);
      chk("rst_wr",    32'(line_read_from_host_o), 0);
      chk("rst_busy",  32'(busy_o), 0);
      chk("rst_done",  32'(done_o), 0);
   endtask

   task automatic check_line();
      for (int b = 0; b < N; b++) chk("line", 32'(mem[b*8 +: 8]), 32'(ld_data[b]));
   endtask

   // vmode: 0 valid held, 1 pattern 1,0,0, 2 random. abort_at>0 resets after that many accepts.
   task automatic run_load(input int vmode, input bit both_start, input int abort_at);
      int  k = 0, pk = 0, nstrobe = 0, cyc = 0, tgl = 0;
      bit  pend = 0, v;
      @(negedge clk_i);
      load_start_i = 1'b1;
      dump_start_i = both_start;
      while (nstrobe < N && cyc < 2000) begin
         @(negedge clk_i);
         cyc++;
         chk("ld_wr", 32'(line_read_from_host_o), 32'(pend));
         if (pend) begin
            chk("ld_off",  32'(offset_o), 32'(8 * pk + 7));
            chk("ld_wdat", 32'(host_input_o), 32'(ld_data[pk]));
            chk("ld_done", 32'(done_o), 32'(pk == N - 1));
            nstrobe++;
         end else begin
            chk("ld_done_gap", 32'(done_o), 0);
         end
         chk("ld_busy", 32'(busy_o), 1);
         chk("ld_rdy",  32'(host_in_ready_o), 32'(k < N));
         chk("ld_ovld", 32'(host_out_valid_o), 0);
         if (abort_at > 0 && k == abort_at) begin
            rst_ni = 1'b0;
            host_in_valid_i = 1'b0;
            load_start_i = 1'b0;
            dump_start_i = 1'b0;
            #1;
            chk_reset_outputs();
            repeat (3) begin
               @(negedge clk_i);
               chk("abort_wr",   32'(line_read_from_host_o), 0);
               chk("abort_busy", 32'(busy_o), 0);
            end
            rst_ni = 1'b1;
            return;
         end
         case (vmode)
            0:       v = 1'b1;
            1:       v = (tgl % 3 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         tgl++;
         load_start_i    = 1'b0;
         dump_start_i    = both_start ? 1'($urandom_range(0, 1)) : 1'b0;
         host_in_valid_i = v;
         host_in_data_i  = (v && k < N) ? ld_data[k] : 8'($urandom);
         pend = v && (k < N);
         pk   = k;
         if (pend) k++;
      end
      chk("ld_timeout", 32'(nstrobe), N);
      host_in_valid_i = 1'b0;
      dump_start_i    = 1'b0;
      @(negedge clk_i);
      chk("ld_end_busy", 32'(busy_o), 0);
      chk("ld_end_done", 32'(done_o), 0);
      chk("ld_end_wr",   32'(line_read_from_host_o), 0);
   endtask

   // rmode: 0 ready held, 1 three-cycle stalls at bytes 5 and 63, 2 random.
   task automatic run_dump(input int rmode);
      int   k = 0, cyc = 0, st5 = 0, st63 = 0;
      bit   fin = 0, stalled = 0, r;
      logic [7:0] held = '0;
      @(negedge clk_i);
      dump_start_i = 1'b1;
      @(negedge clk_i);
      dump_start_i = 1'b0;
      chk("dp_off0",  32'(offset_o), 7);
      chk("dp_vld0",  32'(host_out_valid_o), 0);
      chk("dp_busy0", 32'(busy_o), 1);
      while (!fin && cyc < 2000) begin
         @(negedge clk_i);
         cyc++;
         chk("dp_wr", 32'(line_read_from_host_o), 0);
         if (k == N) begin
            chk("dp_done", 32'(done_o), 1);
            chk("dp_vld_end", 32'(host_out_valid_o), 0);
            fin = 1;
         end else begin
            chk("dp_done_early", 32'(done_o), 0);
            chk("dp_vld", 32'(host_out_valid_o), 1);
            chk("dp_dat", 32'(host_out_data_o), 32'(ld_data[k]));
            if (stalled) chk("dp_hold", 32'(host_out_data_o), 32'(held));
            case (rmode)
               0: r = 1'b1;
               1: begin
                  r = 1'b1;
                  if (k == 5 && st5 < 3) begin r = 1'b0; st5++; end
                  if (k == 63 && st63 < 3) begin r = 1'b0; st63++; end
               end
               default: r = 1'($urandom_range(0, 1));
            endcase
            host_out_ready_i = r;
            stalled = !r;
            held    = host_out_data_o;
            if (r) k++;
         end
      end
      chk("dp_timeout", 32'(fin), 1);
      host_out_ready_i = 1'b0;
      @(negedge clk_i);
      chk("dp_end_busy", 32'(busy_o), 0);
      chk("dp_end_done", 32'(done_o), 0);
   endtask

   initial begin
      rst_ni           = 1'b0;
      load_start_i     = 1'b0;
      dump_start_i     = 1'b0;
      host_in_data_i   = '0;
      host_in_valid_i  = 1'b0;
      host_out_ready_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk_reset_outputs();
      rst_ni = 1'b1;

      for (int i = 0; i < N; i++) ld_data[i] = 8'(i + 1);
      run_load(0, 0, 0);
      check_line();
      run_dump(0);

      for (int i = 0; i < N; i++) ld_data[i] = 8'($urandom);
      run_load(2, 0, 0);
      check_line();
      for (int i = 0; i < N; i++) ld_data[i] = 8'(i + 1);
      run_load(1, 0, 0);
      check_line();
      run_dump(1);

      for (int i = 0; i < N; i++) ld_data[i] = 8'($urandom);
      run_load(2, 1, 0);
      check_line();
      run_dump(2);

      run_load(0, 0, 20);
      for (int i = 0; i < N; i++) ld_data[i] = 8'($urandom);
      run_load(2, 0, 0);
      check_line();
      run_dump(2);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
